// File: rtl/chrom_eval_sequencer.sv
// Sequences one chromosome evaluation between the HPS PIO start/done handshake and the evaluation core.
// Holds the chromosome stable for the run, launches the core once per sequence, sums error, and aborts a stuck core.
module chrom_eval_sequencer #(
  parameter int CHROM_WIDTH    = 992,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ERR_WIDTH      = 32
) (
  input  logic                   iClock,
  input  logic                   iReset_n,
  input  logic                   iStartProcessing,
  input  logic                   iDoneProcessingFeedback,
  output logic                   oReadyToProcess,
  output logic                   oDoneProcessing,
  input  logic [CHROM_WIDTH-1:0] iConcatedChromDescription,
  output logic [CHROM_WIDTH-1:0] oChromLatched,
  input  logic [7:0]             iSequencesToProcess,
  output logic                   oCoreStart,
  output logic [7:0]             oSequenceIndex,
  input  logic                   iCoreSeqDone,
  input  logic [ERR_WIDTH-1:0]   iSeqError,
  output logic [ERR_WIDTH-1:0]   oErrorTotal,
  output logic [31:0]            oCycleCount,
  output logic                   oTimeout,
  output logic [2:0]             oState
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_SEQ = 3'd2,
    S_DONE     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  state_t                 next_state;
  logic [CHROM_WIDTH-1:0] chrom_latched;
  logic [7:0]             seq_count;
  logic [7:0]             seq_index;
  logic [ERR_WIDTH-1:0]   error_total;
  logic [31:0]            cycle_count;
  logic                   timeout_flag;
  logic [WD_WIDTH-1:0]    watchdog;

  logic                   accept;
  logic                   last_seq;
  logic                   wd_expire;
  logic [ERR_WIDTH:0]     err_sum;
  logic [ERR_WIDTH-1:0]   err_sat;
  logic [31:0]            cycle_next;

  assign accept     = (state == S_IDLE) && iStartProcessing;
  assign last_seq   = (({1'b0, seq_index} + 9'd1) == {1'b0, seq_count});
  // A done arriving on the final watchdog cycle takes priority over the abort.
  assign wd_expire  = (state == S_WAIT_SEQ) && !iCoreSeqDone && (watchdog == WD_LAST);
  assign err_sum    = {1'b0, error_total} + {1'b0, iSeqError};
  assign err_sat    = err_sum[ERR_WIDTH] ? {ERR_WIDTH{1'b1}} : err_sum[ERR_WIDTH-1:0];
  assign cycle_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (iStartProcessing) begin
          next_state = (iSequencesToProcess == 8'd0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        next_state = S_WAIT_SEQ;
      end
      S_WAIT_SEQ: begin
        if (iCoreSeqDone) begin
          next_state = last_seq ? S_DONE : S_LAUNCH;
        end else if (wd_expire) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (iDoneProcessingFeedback) begin
          next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Start must drop first so a level held over from the last run cannot re-trigger.
        if (!iStartProcessing && !iDoneProcessingFeedback) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    oReadyToProcess = 1'b0;
    oDoneProcessing = 1'b0;
    oCoreStart      = 1'b0;
    case (state)
      S_IDLE:   oReadyToProcess = 1'b1;
      S_LAUNCH: oCoreStart      = 1'b1;
      S_DONE:   oDoneProcessing = 1'b1;
      default: begin
        oReadyToProcess = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      chrom_latched <= '0;
      seq_count     <= '0;
      seq_index     <= '0;
      error_total   <= '0;
      cycle_count   <= '0;
      timeout_flag  <= 1'b0;
      watchdog      <= '0;
    end else if (accept) begin
      chrom_latched <= iConcatedChromDescription;
      seq_count     <= iSequencesToProcess;
      seq_index     <= '0;
      error_total   <= '0;
      cycle_count   <= '0;
      timeout_flag  <= 1'b0;
      watchdog      <= '0;
    end else begin
      case (state)
        S_LAUNCH: begin
          cycle_count <= cycle_next;
          watchdog    <= '0;
        end
        S_WAIT_SEQ: begin
          cycle_count <= cycle_next;
          watchdog    <= watchdog + 1'b1;
          if (iCoreSeqDone) begin
            error_total <= err_sat;
            if (!last_seq) begin
              seq_index <= seq_index + 8'd1;
            end
          end else if (wd_expire) begin
            timeout_flag <= 1'b1;
          end
        end
        default: begin
          watchdog <= watchdog;
        end
      endcase
    end
  end

  assign oChromLatched  = chrom_latched;
  assign oSequenceIndex = seq_index;
  assign oErrorTotal    = error_total;
  assign oCycleCount    = cycle_count;
  assign oTimeout       = timeout_flag;
  assign oState         = state;

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Self-checking bench for chrom_eval_sequencer: a small core model answers launches while
// expected launch indices and error totals are queued at stimulus time and compared on completion.
module tb_chrom_eval_sequencer;

  localparam int CW = 992;
  localparam int EW = 32;
  localparam int TO = 16;

  logic          iClock = 1'b0;
  logic          iReset_n = 1'b0;
  logic          iStartProcessing = 1'b0;
  logic          iDoneProcessingFeedback = 1'b0;
  logic          oReadyToProcess;
  logic          oDoneProcessing;
  logic [CW-1:0] iConcatedChromDescription = '0;
  logic [CW-1:0] oChromLatched;
  logic [7:0]    iSequencesToProcess = '0;
  logic          oCoreStart;
  logic [7:0]    oSequenceIndex;
  logic          iCoreSeqDone = 1'b0;
  logic [EW-1:0] iSeqError = '0;
  logic [EW-1:0] oErrorTotal;
  logic [31:0]   oCycleCount;
  logic          oTimeout;
  logic [2:0]    oState;

  chrom_eval_sequencer #(
    .CHROM_WIDTH(CW),
    .TIMEOUT_CYCLES(TO),
    .ERR_WIDTH(EW)
  ) dut (
    .iClock(iClock),
    .iReset_n(iReset_n),
    .iStartProcessing(iStartProcessing),
    .iDoneProcessingFeedback(iDoneProcessingFeedback),
    .oReadyToProcess(oReadyToProcess),
    .oDoneProcessing(oDoneProcessing),
    .iConcatedChromDescription(iConcatedChromDescription),
    .oChromLatched(oChromLatched),
    .iSequencesToProcess(iSequencesToProcess),
    .oCoreStart(oCoreStart),
    .oSequenceIndex(oSequenceIndex),
    .iCoreSeqDone(iCoreSeqDone),
    .iSeqError(iSeqError),
    .oErrorTotal(oErrorTotal),
    .oCycleCount(oCycleCount),
    .oTimeout(oTimeout),
    .oState(oState)
  );

  always #5 iClock = ~iClock;

  int          n_vec = 0;
  int          n_err = 0;
  int          core_cnt = 0;
  logic [31:0] err_q[$];
  int          exp_idx_q[$];
  int          obs_idx_q[$];
  logic        core_seen_start;
  logic [7:0]  core_seen_index;

  function automatic logic [CW-1:0] rand_chrom();
    logic [CW-1:0] p;
    for (int i = 0; i < CW / 32; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Core model: answers a launch with a done pulse 4 cycles later, popping the queued error.
  task automatic tick_core(input bit respond);
    @(negedge iClock);
    core_seen_start = oCoreStart;
    core_seen_index = oSequenceIndex;
    iCoreSeqDone = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && respond) begin
        iCoreSeqDone = 1'b1;
        iSeqError = (err_q.size() > 0) ? err_q.pop_front() : 32'h0;
      end
    end
    if (oCoreStart) core_cnt = 4;
  endtask

  task automatic run_until_done(input bit respond, input int budget, input bit change_mid,
                                input logic [CW-1:0] chrom_mid, output bit reached, output int since_launch);
    int  first;
    bit  changed;
    first = -1;
    changed = 0;
    reached = 0;
    since_launch = -1;
    for (int c = 0; c < budget; c++) begin
      tick_core(respond);
      if (core_seen_start) begin
        obs_idx_q.push_back(int'(core_seen_index));
        if (first < 0) first = c;
      end
      if (change_mid && !changed && oState == 3'd2) begin
        iConcatedChromDescription = chrom_mid;
        changed = 1;
      end
      if (oDoneProcessing) begin
        reached = 1;
        since_launch = (first < 0) ? -1 : c - first;
        break;
      end
    end
  endtask

  task automatic release_handshake();
    iDoneProcessingFeedback = 1'b1;
    @(negedge iClock);
    iDoneProcessingFeedback = 1'b0;
    @(negedge iClock);
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (oReadyToProcess !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %0b expected 1", oReadyToProcess); end
    n_vec++; if (oState !== 3'd0) begin n_err++; $display("[TB] FAIL reset_state: got %0d expected 0", oState); end
    n_vec++; if ({oDoneProcessing, oCoreStart, oTimeout} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 000", {oDoneProcessing, oCoreStart, oTimeout}); end
    n_vec++; if ({oErrorTotal, oCycleCount, oSequenceIndex} !== 72'h0) begin n_err++; $display("[TB] FAIL reset_results: got %h expected 0", {oErrorTotal, oCycleCount, oSequenceIndex}); end
    n_vec++; if (oChromLatched !== '0) begin n_err++; $display("[TB] FAIL reset_chrom: got nonzero expected 0"); end
    @(negedge iClock);
    iReset_n = 1'b1;
    @(negedge iClock);
  endtask

  task automatic test_normal_run();
    logic [CW-1:0] chrom;
    logic [31:0]   exp_total;
    logic [31:0]   errs[3];
    bit            reached;
    int            since;
    int            e, o;
    chrom = rand_chrom();
    errs = '{32'd5, 32'd7, 32'd9};
    exp_total = 0;
    obs_idx_q.delete();
    for (int i = 0; i < 3; i++) begin
      err_q.push_back(errs[i]);
      exp_idx_q.push_back(i);
      exp_total = sat_add(exp_total, errs[i]);
    end
    iConcatedChromDescription = chrom;
    iSequencesToProcess = 8'd3;
    iStartProcessing = 1'b1;
    @(posedge iClock);
    #1 iStartProcessing = 1'b0;
    run_until_done(1, 200, 0, '0, reached, since);
    n_vec++; if (!reached) begin n_err++; $display("[TB] FAIL normal_done_reached: got 0 expected 1"); end
    while (exp_idx_q.size() > 0) begin
      e = exp_idx_q.pop_front();
      o = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
      n_vec++; if (o !== e) begin n_err++; $display("[TB] FAIL normal_start_index: got %0d expected %0d", o, e); end
    end
    n_vec++; if (obs_idx_q.size() !== 0) begin n_err++; $display("[TB] FAIL normal_extra_starts: got %0d expected 0", obs_idx_q.size()); end
    n_vec++; if (oErrorTotal !== exp_total) begin n_err++; $display("[TB] FAIL normal_error_total: got %0d expected %0d", oErrorTotal, exp_total); end
    n_vec++; if (oCycleCount !== 32'd15) begin n_err++; $display("[TB] FAIL normal_cycle_count: got %0d expected 15", oCycleCount); end
    n_vec++; if (oSequenceIndex !== 8'd2) begin n_err++; $display("[TB] FAIL normal_index_held: got %0d expected 2", oSequenceIndex); end
    n_vec++; if (oChromLatched !== chrom) begin n_err++; $display("[TB] FAIL normal_chrom_latched: got differs expected match"); end
    n_vec++; if ({oTimeout, oReadyToProcess, oState} !== 5'b00011) begin n_err++; $display("[TB] FAIL normal_done_state: got %b expected 00011", {oTimeout, oReadyToProcess, oState}); end
    iDoneProcessingFeedback = 1'b1;
    @(negedge iClock);
    n_vec++; if ({oDoneProcessing, oReadyToProcess, oState} !== 5'b00100) begin n_err++; $display("[TB] FAIL normal_release: got %b expected 00100", {oDoneProcessing, oReadyToProcess, oState}); end
    iDoneProcessingFeedback = 1'b0;
    @(negedge iClock);
    n_vec++; if ({oReadyToProcess, oState} !== 4'b1000) begin n_err++; $display("[TB] FAIL normal_back_idle: got %b expected 1000", {oReadyToProcess, oState}); end
    n_vec++; if (oErrorTotal !== exp_total) begin n_err++; $display("[TB] FAIL normal_total_held: got %0d expected %0d", oErrorTotal, exp_total); end
  endtask

  task automatic test_zero_count();
    logic [CW-1:0] chrom;
    chrom = rand_chrom();
    iConcatedChromDescription = chrom;
    iSequencesToProcess = 8'd0;
    iStartProcessing = 1'b1;
    @(negedge iClock);
    iStartProcessing = 1'b0;
    n_vec++; if ({oDoneProcessing, oState} !== 4'b1011) begin n_err++; $display("[TB] FAIL zero_done: got %b expected 1011", {oDoneProcessing, oState}); end
    n_vec++; if ({oErrorTotal, oCycleCount} !== 64'h0) begin n_err++; $display("[TB] FAIL zero_results: got %h expected 0", {oErrorTotal, oCycleCount}); end
    n_vec++; if (oCoreStart !== 1'b0) begin n_err++; $display("[TB] FAIL zero_no_start: got %0b expected 0", oCoreStart); end
    n_vec++; if (oChromLatched !== chrom) begin n_err++; $display("[TB] FAIL zero_chrom: got differs expected match"); end
    release_handshake();
  endtask

  task automatic test_timeout();
    bit reached;
    int since;
    int o;
    obs_idx_q.delete();
    exp_idx_q.push_back(0);
    iSequencesToProcess = 8'd2;
    iStartProcessing = 1'b1;
    @(posedge iClock);
    #1 iStartProcessing = 1'b0;
    run_until_done(0, 100, 0, '0, reached, since);
    n_vec++; if (!reached) begin n_err++; $display("[TB] FAIL timeout_done_reached: got 0 expected 1"); end
    n_vec++; if (since !== TO + 1) begin n_err++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", since, TO + 1); end
    n_vec++; if (oTimeout !== 1'b1) begin n_err++; $display("[TB] FAIL timeout_flag: got %0b expected 1", oTimeout); end
    n_vec++; if (oSequenceIndex !== 8'd0) begin n_err++; $display("[TB] FAIL timeout_index: got %0d expected 0", oSequenceIndex); end
    n_vec++; if (oCycleCount !== 32'(TO + 1)) begin n_err++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", oCycleCount, TO + 1); end
    o = (obs_idx_q.size() == 1) ? obs_idx_q.pop_front() : -1;
    n_vec++; if (o !== exp_idx_q.pop_front()) begin n_err++; $display("[TB] FAIL timeout_starts: got %0d expected one start at 0", o); end
    iSeqError = 32'd100;
    iCoreSeqDone = 1'b1;
    @(negedge iClock);
    iCoreSeqDone = 1'b0;
    @(negedge iClock);
    n_vec++; if ({oState, oErrorTotal} !== {3'd3, 32'd0}) begin n_err++; $display("[TB] FAIL timeout_late_done: got state %0d total %0d expected 3 0", oState, oErrorTotal); end
    release_handshake();
    n_vec++; if ({oReadyToProcess, oTimeout} !== 2'b11) begin n_err++; $display("[TB] FAIL timeout_sticky: got %b expected 11", {oReadyToProcess, oTimeout}); end
  endtask

  task automatic test_saturation_isolation();
    logic [CW-1:0] chrom;
    logic [31:0]   exp_total;
    bit            reached;
    int            since;
    int            e, o;
    chrom = rand_chrom();
    obs_idx_q.delete();
    exp_total = sat_add(sat_add(32'h0, 32'hFFFF_FFF0), 32'h20);
    err_q.push_back(32'hFFFF_FFF0);
    err_q.push_back(32'h20);
    exp_idx_q.push_back(0);
    exp_idx_q.push_back(1);
    iConcatedChromDescription = chrom;
    iSequencesToProcess = 8'd2;
    iStartProcessing = 1'b1;
    @(posedge iClock);
    #1 iStartProcessing = 1'b0;
    run_until_done(1, 200, 1, ~chrom, reached, since);
    n_vec++; if (!reached) begin n_err++; $display("[TB] FAIL sat_done_reached: got 0 expected 1"); end
    while (exp_idx_q.size() > 0) begin
      e = exp_idx_q.pop_front();
      o = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
      n_vec++; if (o !== e) begin n_err++; $display("[TB] FAIL sat_start_index: got %0d expected %0d", o, e); end
    end
    n_vec++; if (oErrorTotal !== exp_total) begin n_err++; $display("[TB] FAIL sat_error_total: got %h expected %h", oErrorTotal, exp_total); end
    n_vec++; if (oChromLatched !== chrom) begin n_err++; $display("[TB] FAIL chrom_isolation: got changed expected held"); end
    n_vec++; if (oTimeout !== 1'b0) begin n_err++; $display("[TB] FAIL sat_timeout_cleared: got %0b expected 0", oTimeout); end
    release_handshake();
  endtask

  task automatic test_back_to_back();
    bit reached;
    int since;
    obs_idx_q.delete();
    err_q.push_back(32'd11);
    iSequencesToProcess = 8'd1;
    iStartProcessing = 1'b1;
    run_until_done(1, 100, 0, '0, reached, since);
    n_vec++; if (!reached || oErrorTotal !== 32'd11) begin n_err++; $display("[TB] FAIL hyg_first_run: got reached %0b total %0d expected 1 11", reached, oErrorTotal); end
    iDoneProcessingFeedback = 1'b1;
    @(negedge iClock);
    iDoneProcessingFeedback = 1'b0;
    obs_idx_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick_core(1);
      n_vec++; if ({oState, core_seen_start} !== {3'd4, 1'b0}) begin n_err++; $display("[TB] FAIL hyg_stay_release: got state %0d start %0b expected 4 0", oState, core_seen_start); end
    end
    iStartProcessing = 1'b0;
    @(negedge iClock);
    n_vec++; if ({oReadyToProcess, oState} !== 4'b1000) begin n_err++; $display("[TB] FAIL hyg_idle: got %b expected 1000", {oReadyToProcess, oState}); end
    err_q.push_back(32'd3);
    iStartProcessing = 1'b1;
    @(posedge iClock);
    #1 iStartProcessing = 1'b0;
    @(negedge iClock);
    n_vec++; if ({oState, oErrorTotal, oCycleCount} !== {3'd1, 32'd0, 32'd0}) begin n_err++; $display("[TB] FAIL hyg_cleared: got state %0d total %0d cycles %0d expected 1 0 0", oState, oErrorTotal, oCycleCount); end
    core_cnt = 4;
    run_until_done(1, 100, 0, '0, reached, since);
    n_vec++; if (oErrorTotal !== 32'd3) begin n_err++; $display("[TB] FAIL hyg_second_total: got %0d expected 3", oErrorTotal); end
    n_vec++; if (oCycleCount !== 32'd5) begin n_err++; $display("[TB] FAIL hyg_second_cycles: got %0d expected 5", oCycleCount); end
    release_handshake();
  endtask

  task automatic test_async_reset();
    bit seen_wait;
    bit seen_done;
    seen_wait = 0;
    seen_done = 0;
    err_q.push_back(32'd5);
    iConcatedChromDescription = rand_chrom();
    iSequencesToProcess = 8'd3;
    iStartProcessing = 1'b1;
    @(posedge iClock);
    #1 iStartProcessing = 1'b0;
    for (int c = 0; c < 20 && !seen_wait; c++) begin
      tick_core(1);
      if (oState == 3'd2) seen_wait = 1;
    end
    n_vec++; if (!seen_wait) begin n_err++; $display("[TB] FAIL rst_reach_wait: got 0 expected 1"); end
    #2 iReset_n = 1'b0;
    #1;
    n_vec++; if ({oReadyToProcess, oDoneProcessing, oCoreStart, oTimeout, oState} !== 7'b1000000) begin n_err++; $display("[TB] FAIL rst_async_flags: got %b expected 1000000", {oReadyToProcess, oDoneProcessing, oCoreStart, oTimeout, oState}); end
    n_vec++; if ({oErrorTotal, oCycleCount, oSequenceIndex} !== 72'h0 || oChromLatched !== '0) begin n_err++; $display("[TB] FAIL rst_async_results: got %h expected 0", {oErrorTotal, oCycleCount, oSequenceIndex}); end
    core_cnt = 0;
    err_q.delete();
    iCoreSeqDone = 1'b0;
    @(negedge iClock);
    iReset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick_core(1);
      if (oDoneProcessing) seen_done = 1;
    end
    n_vec++; if (seen_done) begin n_err++; $display("[TB] FAIL rst_no_done: got 1 expected 0"); end
    n_vec++; if ({oReadyToProcess, oState} !== 4'b1000) begin n_err++; $display("[TB] FAIL rst_ready_after: got %b expected 1000", {oReadyToProcess, oState}); end
  endtask

  initial begin
    $display("[TB] starting chrom_eval_sequencer bench");
    test_reset();
    test_normal_run();
    test_zero_count();
    test_timeout();
    test_saturation_isolation();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
